// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch and load/store ports, the arbiter and the RAM.
// The arbiter uses the slave view; the core/RAM side uses the master view.
interface mem_port_arbiter_if #(
    parameter int dataW = 32,
    parameter int AddrW = 32
);
    logic             IFReq;
    logic [AddrW-1:0] IFAddr;
    logic             IFAck;
    logic [dataW-1:0] IFData;
    logic             IFErr;

    logic             LSReq;
    logic [AddrW-1:0] LSAddr;
    logic             LSWrite;
    logic [1:0]       LSSize;
    logic             LSUnsigned;
    logic [dataW-1:0] LSWData;
    logic             LSAck;
    logic [dataW-1:0] LSRData;
    logic             LSErr;

    logic [AddrW-1:0] RAMAddr;
    logic [dataW-1:0] RAMDataIn;
    logic             RAMWriteControl;
    logic [dataW-1:0] RAMOut;
    logic             Busy;

    modport slave (
        input  IFReq, IFAddr, LSReq, LSAddr, LSWrite, LSSize, LSUnsigned, LSWData, RAMOut,
        output IFAck, IFData, IFErr, LSAck, LSRData, LSErr,
        output RAMAddr, RAMDataIn, RAMWriteControl, Busy
    );

    modport master (
        output IFReq, IFAddr, LSReq, LSAddr, LSWrite, LSSize, LSUnsigned, LSWData, RAMOut,
        input  IFAck, IFData, IFErr, LSAck, LSRData, LSErr,
        input  RAMAddr, RAMDataIn, RAMWriteControl, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-port word RAM between instruction fetch and load/store, with
// sub-word load extraction, read-modify-write stores and alignment checking.
module mem_port_arbiter #(
    parameter int dataW        = 32,
    parameter int AddrW        = 32,
    parameter int MaxDataBurst = 4
) (
    input logic               clock,
    input logic               nReset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR} state_t;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [3:0] MAX_BURST = 4'(MaxDataBurst);

    state_t           state;
    logic [3:0]       burst_cnt;
    logic             lat_is_if;
    logic             lat_write;
    logic             lat_unsigned;
    logic             lat_err;
    logic [1:0]       lat_size;
    logic [1:0]       lat_lane;
    logic [dataW-1:0] lat_wdata;

    logic             grant_if;
    logic             grant_ls;
    logic [AddrW-1:0] sel_addr;
    logic             sel_err;
    logic             word_store;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [dataW-1:0] extract_load(input logic [dataW-1:0] word,
                                                      input logic [1:0] size,
                                                      input logic [1:0] lane,
                                                      input logic       uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{(dataW-8){b[7] & ~uns}}, b};
            SZ_HALF: return {{(dataW-16){h[15] & ~uns}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [dataW-1:0] merge_lane(input logic [dataW-1:0] word,
                                                    input logic [dataW-1:0] wdata,
                                                    input logic [1:0]       size,
                                                    input logic [1:0]       lane);
        logic [dataW-1:0] m;
        m = word;
        if (size == SZ_BYTE)  m[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (lane[1])     m[31:16] = wdata[15:0];
        else                  m[15:0]  = wdata[15:0];
        return m;
    endfunction

    // An acked port is ignored for one cycle, but a raw LSReq still holds IF back
    // unless the burst limit has been reached.
    always_comb begin
        grant_if   = bus.IFReq && !bus.IFAck && ((burst_cnt >= MAX_BURST) || !bus.LSReq);
        grant_ls   = bus.LSReq && !bus.LSAck && !grant_if;
        sel_addr   = grant_if ? bus.IFAddr : bus.LSAddr;
        sel_err    = grant_if ? (bus.IFAddr[1:0] != 2'b00) : misaligned(bus.LSSize, bus.LSAddr[1:0]);
        word_store = grant_ls && bus.LSWrite && (bus.LSSize == SZ_WORD) && !sel_err;
    end

    assign bus.Busy = (state != IDLE);

    // NOTE: every register here, including outputs, is updated with <= so all of
    // them see pre-edge values; the async reset also drops RAMWriteControl at once.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state               <= IDLE;
            burst_cnt           <= '0;
            lat_is_if           <= 1'b0;
            lat_write           <= 1'b0;
            lat_unsigned        <= 1'b0;
            lat_err             <= 1'b0;
            lat_size            <= '0;
            lat_lane            <= '0;
            lat_wdata           <= '0;
            bus.IFAck           <= 1'b0;
            bus.IFData          <= '0;
            bus.IFErr           <= 1'b0;
            bus.LSAck           <= 1'b0;
            bus.LSRData         <= '0;
            bus.LSErr           <= 1'b0;
            bus.RAMAddr         <= '0;
            bus.RAMDataIn       <= '0;
            bus.RAMWriteControl <= 1'b0;
        end else begin
            bus.IFAck <= 1'b0;
            bus.IFErr <= 1'b0;
            bus.LSAck <= 1'b0;
            bus.LSErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_ls) begin
                        state               <= ACCESS;
                        lat_is_if           <= grant_if;
                        lat_write           <= grant_ls && bus.LSWrite;
                        lat_size            <= grant_if ? SZ_WORD : bus.LSSize;
                        lat_lane            <= sel_addr[1:0];
                        lat_unsigned        <= bus.LSUnsigned;
                        lat_wdata           <= bus.LSWData;
                        lat_err             <= sel_err;
                        bus.RAMAddr         <= {sel_addr[AddrW-1:2], 2'b00};
                        bus.RAMWriteControl <= word_store;
                        bus.RAMDataIn       <= word_store ? bus.LSWData : '0;
                    end
                    if (grant_if)
                        burst_cnt <= '0;
                    else if (grant_ls && bus.IFReq && burst_cnt != 4'hF)
                        burst_cnt <= burst_cnt + 4'd1;
                end
                ACCESS: begin
                    if (lat_write && !lat_err && lat_size != SZ_WORD) begin
                        state               <= MERGE_WR;
                        bus.RAMWriteControl <= 1'b1;
                        bus.RAMDataIn       <= merge_lane(bus.RAMOut, lat_wdata, lat_size, lat_lane);
                    end else begin
                        state               <= IDLE;
                        bus.RAMAddr         <= '0;
                        bus.RAMDataIn       <= '0;
                        bus.RAMWriteControl <= 1'b0;
                        if (lat_is_if) begin
                            bus.IFAck  <= 1'b1;
                            bus.IFErr  <= lat_err;
                            bus.IFData <= lat_err ? '0 : bus.RAMOut;
                        end else begin
                            bus.LSAck   <= 1'b1;
                            bus.LSErr   <= lat_err;
                            bus.LSRData <= (lat_err || lat_write) ? '0
                                         : extract_load(bus.RAMOut, lat_size, lat_lane, lat_unsigned);
                        end
                    end
                end
                MERGE_WR: begin
                    state               <= IDLE;
                    bus.RAMAddr         <= '0;
                    bus.RAMDataIn       <= '0;
                    bus.RAMWriteControl <= 1'b0;
                    bus.LSAck           <= 1'b1;
                    bus.LSRData         <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural RAM, scoreboard of expected
// completions, immediate assertions at every comparison.
module tb_mem_port_arbiter;
    typedef struct {
        string       tag;
        logic        is_if;
        logic [31:0] data;
        logic        err;
        int          lat;
        logic [7:0]  we_mask;
    } exp_t;

    logic        clock;
    logic        nReset;
    logic [31:0] ram [0:1023];
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;

    mem_port_arbiter_if #(.dataW(32), .AddrW(32)) bus ();

    mem_port_arbiter #(.dataW(32), .AddrW(32), .MaxDataBurst(4)) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb bus.RAMOut = ram[bus.RAMAddr[11:2]];
    always @(posedge clock) if (bus.RAMWriteControl) ram[bus.RAMAddr[11:2]] <= bus.RAMDataIn;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ls_access(input string tag, input logic [31:0] addr, input logic wr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                             input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                             input logic [7:0] exp_we);
        exp_t e;
        int   cyc;
        logic got;
        logic [7:0] we_seen;
        e.tag = tag; e.is_if = 1'b0; e.data = exp_data; e.err = exp_err;
        e.lat = exp_lat; e.we_mask = exp_we;
        sb.push_back(e);
        bus.LSReq = 1'b1; bus.LSAddr = addr; bus.LSWrite = wr; bus.LSSize = size;
        bus.LSUnsigned = uns; bus.LSWData = wdata;
        cyc = 0; got = 1'b0; we_seen = '0;
        while (!got && cyc < 10) begin
            tick();
            cyc++;
            if (bus.RAMWriteControl && cyc < 8) we_seen[cyc] = 1'b1;
            if (bus.LSAck) begin
                got = 1'b1;
                e = sb.pop_front();
                check({e.tag, ".rdata"}, bus.LSRData, e.data);
                check({e.tag, ".err"}, bus.LSErr, e.err);
                check({e.tag, ".latency"}, cyc, e.lat);
                check({e.tag, ".we_cycles"}, we_seen, e.we_mask);
            end
        end
        bus.LSReq = 1'b0;
        check({tag, ".acked"}, got, 1'b1);
        if (!got) void'(sb.pop_front());
        tick();
        check({tag, ".ack_pulse"}, {bus.LSAck, bus.LSErr}, 2'b00);
    endtask

    task automatic if_access(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        int   cyc;
        logic got;
        e.tag = tag; e.is_if = 1'b1; e.data = exp_data; e.err = exp_err;
        e.lat = 2; e.we_mask = '0;
        sb.push_back(e);
        bus.IFReq = 1'b1; bus.IFAddr = addr;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            tick();
            cyc++;
            if (bus.IFAck) begin
                got = 1'b1;
                e = sb.pop_front();
                check({e.tag, ".data"}, bus.IFData, e.data);
                check({e.tag, ".err"}, bus.IFErr, e.err);
                check({e.tag, ".latency"}, cyc, e.lat);
            end
        end
        bus.IFReq = 1'b0;
        check({tag, ".acked"}, got, 1'b1);
        if (!got) void'(sb.pop_front());
        tick();
    endtask

    initial begin
        exp_t e;
        int   n_acks;
        logic prev_if, prev_ls, ack_seen;

        nReset = 1'b0;
        bus.IFReq = 1'b0; bus.IFAddr = '0;
        bus.LSReq = 1'b0; bus.LSAddr = '0; bus.LSWrite = 1'b0; bus.LSSize = 2'b10;
        bus.LSUnsigned = 1'b0; bus.LSWData = '0;
        for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        ram[32'h40 >> 2]  <= 32'h12345678;
        ram[32'h100 >> 2] <= 32'h80FF7F01;
        ram[32'h200 >> 2] <= 32'hAABBCCDD;
        ram[32'h300 >> 2] <= 32'hCAFEF00D;
        tick();
        tick();

        // Reset state
        check("rst.IFAck", bus.IFAck, 1'b0);
        check("rst.IFData", bus.IFData, 32'h0);
        check("rst.IFErr", bus.IFErr, 1'b0);
        check("rst.LSAck", bus.LSAck, 1'b0);
        check("rst.LSRData", bus.LSRData, 32'h0);
        check("rst.LSErr", bus.LSErr, 1'b0);
        check("rst.RAMAddr", bus.RAMAddr, 32'h0);
        check("rst.RAMDataIn", bus.RAMDataIn, 32'h0);
        check("rst.RAMWriteControl", bus.RAMWriteControl, 1'b0);
        check("rst.Busy", bus.Busy, 1'b0);
        nReset = 1'b1;
        tick();

        // Fetch 0x40, cycle by cycle
        bus.IFReq = 1'b1; bus.IFAddr = 32'h40;
        check("fetch.c0.Busy", bus.Busy, 1'b0);
        tick();
        check("fetch.c1.RAMAddr", bus.RAMAddr, 32'h40);
        check("fetch.c1.Busy", bus.Busy, 1'b1);
        check("fetch.c1.IFAck", bus.IFAck, 1'b0);
        tick();
        check("fetch.c2.IFAck", bus.IFAck, 1'b1);
        check("fetch.c2.IFData", bus.IFData, 32'h12345678);
        check("fetch.c2.IFErr", bus.IFErr, 1'b0);
        check("fetch.c2.Busy", bus.Busy, 1'b0);
        check("fetch.c2.RAMAddr", bus.RAMAddr, 32'h0);
        bus.IFReq = 1'b0;
        tick();
        check("fetch.c3.IFAck", bus.IFAck, 1'b0);
        check("fetch.c3.IFData_held", bus.IFData, 32'h12345678);

        // Sub-word loads from 0x80FF7F01
        ls_access("lb_101",  32'h101, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000007F, 1'b0, 2, 8'h00);
        ls_access("lb_102",  32'h102, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 8'h00);
        ls_access("lbu_102", 32'h102, 1'b0, 2'b00, 1'b1, 32'h0, 32'h000000FF, 1'b0, 2, 8'h00);
        ls_access("lh_102",  32'h102, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 2, 8'h00);
        ls_access("lhu_102", 32'h102, 1'b0, 2'b01, 1'b1, 32'h0, 32'h000080FF, 1'b0, 2, 8'h00);
        ls_access("lh_100",  32'h100, 1'b0, 2'b01, 1'b0, 32'h0, 32'h00007F01, 1'b0, 2, 8'h00);
        ls_access("lw_100",  32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'h80FF7F01, 1'b0, 2, 8'h00);

        // Read-modify-write and word stores
        ls_access("sb_201", 32'h201, 1'b1, 2'b00, 1'b0, 32'h00000011, 32'h0, 1'b0, 3, 8'h04);
        check("sb_201.ram", ram[32'h200 >> 2], 32'hAABB11DD);
        ls_access("sh_202", 32'h202, 1'b1, 2'b01, 1'b0, 32'h00005566, 32'h0, 1'b0, 3, 8'h04);
        check("sh_202.ram", ram[32'h200 >> 2], 32'h556611DD);
        ls_access("sw_204", 32'h204, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2, 8'h02);
        check("sw_204.ram", ram[32'h204 >> 2], 32'hDEADBEEF);

        // Alignment and size errors
        ls_access("sw_203", 32'h203, 1'b1, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b1, 2, 8'h00);
        check("sw_203.ram", ram[32'h200 >> 2], 32'h556611DD);
        ls_access("sh_201", 32'h201, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 1'b1, 2, 8'h00);
        check("sh_201.ram", ram[32'h200 >> 2], 32'h556611DD);
        ls_access("size11", 32'h100, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 2, 8'h00);
        ls_access("lh_101", 32'h101, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 2, 8'h00);
        if_access("fetch_42", 32'h42, 32'h0, 1'b1);
        if_access("fetch_40", 32'h40, 32'h12345678, 1'b0);

        // Burst arbitration with both requesters held high
        for (int k = 0; k < 10; k++) begin
            e.tag = $sformatf("arb.%0d", k);
            e.is_if = (k == 4) || (k == 9);
            e.data = e.is_if ? 32'h12345678 : 32'hCAFEF00D;
            e.err = 1'b0; e.lat = 0; e.we_mask = '0;
            sb.push_back(e);
        end
        bus.IFReq = 1'b1; bus.IFAddr = 32'h40;
        bus.LSReq = 1'b1; bus.LSAddr = 32'h300; bus.LSWrite = 1'b0; bus.LSSize = 2'b10;
        n_acks = 0; prev_if = 1'b0; prev_ls = 1'b0;
        for (int c = 0; c < 80 && n_acks < 10; c++) begin
            tick();
            check("arb.both_acks", bus.IFAck & bus.LSAck, 1'b0);
            check("arb.dup_ack", (bus.IFAck & prev_if) | (bus.LSAck & prev_ls), 1'b0);
            prev_if = bus.IFAck;
            prev_ls = bus.LSAck;
            if ((bus.IFAck || bus.LSAck) && sb.size() > 0) begin
                e = sb.pop_front();
                n_acks++;
                check({e.tag, ".port_is_if"}, bus.IFAck, e.is_if);
                check({e.tag, ".data"}, bus.IFAck ? bus.IFData : bus.LSRData, e.data);
            end
        end
        bus.IFReq = 1'b0;
        bus.LSReq = 1'b0;
        check("arb.ack_count", n_acks, 10);
        tick();
        tick();
        check("arb.idle_after", bus.Busy, 1'b0);
        check("sb.empty", sb.size(), 0);

        // Reset during MERGE_WR of SB 0x201
        bus.LSReq = 1'b1; bus.LSAddr = 32'h201; bus.LSWrite = 1'b1; bus.LSSize = 2'b00;
        bus.LSWData = 32'h00000077;
        tick();
        tick();
        check("abort.c2.RAMWriteControl", bus.RAMWriteControl, 1'b1);
        #1 nReset = 1'b0;
        #1;
        check("abort.we_dropped", bus.RAMWriteControl, 1'b0);
        check("abort.busy_dropped", bus.Busy, 1'b0);
        bus.LSReq = 1'b0;
        ack_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            ack_seen = ack_seen | bus.LSAck;
        end
        nReset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            ack_seen = ack_seen | bus.LSAck;
        end
        check("abort.no_ack", ack_seen, 1'b0);
        check("abort.ram_kept", ram[32'h200 >> 2], 32'h556611DD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port zero-delay RAM between the instruction-fetch (IF) port and the load/store (LS) port of the RV32I core.
- Sequences every access through a small FSM and registers all responses.
- The RAM stores only whole words, so the block performs read-modify-write for byte and halfword stores.
- Extracts and extends sub-word loads, and flags misaligned or illegal accesses.

Parameters:
- dataW, 32, data word width.
- AddrW, 32, byte address width.
- MaxDataBurst, 4, maximum consecutive LS grants while IF is pending before IF is forced through (range 1..15).

Ports:
- clock  in  1  system clock.
- nReset  in  1  reset.
- IFReq  in  1  fetch request; held high until IFAck.
- IFAddr  in  AddrW  fetch byte address.
- IFAck  out  1  one-cycle completion pulse.
- IFData  out  dataW  fetched word; valid while IFAck=1 and held until the next IF completion.
- IFErr  out  1  valid with IFAck; 1 = misaligned fetch.
- LSReq  in  1  load/store request; held high until LSAck.
- LSAddr  in  AddrW  byte address.
- LSWrite  in  1  1 = store, 0 = load.
- LSSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- LSUnsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- LSWData  in  dataW  store data, right-aligned (bits [7:0] for byte).
- LSAck  out  1  one-cycle completion pulse.
- LSRData  out  dataW  extended load data; valid while LSAck=1.
- LSErr  out  1  valid with LSAck; 1 = misaligned or illegal size.
- RAMAddr  out  AddrW  to RAM; bits [1:0] always 0.
- RAMDataIn  out  dataW  to RAM write data.
- RAMWriteControl  out  1  to RAM write enable.
- RAMOut  in  dataW  RAM read data; combinational in RAMAddr.
- Busy  out  1  FSM not in IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - While nReset=0, state=IDLE and the burst counter is 0.
  - All outputs, including the held IFData and LSRData, are 0.
  - Assertion mid-operation aborts the access: no ack is issued and RAMWriteControl drops immediately, so an in-flight write does not occur.
- States: IDLE, ACCESS, MERGE_WR.
- IDLE:
  - RAMAddr=0, RAMWriteControl=0.
  - Arbitration samples IFReq and LSReq.
  - A port whose ack is high this cycle is ignored, which prevents double-accept.
  - On grant, latch address, size, write, unsigned and wdata, then go to ACCESS.
- Arbitration:
  - LS has priority.
  - The burst counter increments on each LS grant made while IFReq=1; otherwise it holds.
  - If counter==MaxDataBurst and IFReq=1, IF is granted instead of LS.
  - Any IF grant clears the counter.
- Alignment errors:
  - Word with addr[1:0]!=0, half with addr[0]=1, LSSize=11, or fetch with addr[1:0]!=0 is an error.
  - The access still passes through ACCESS with RAMWriteControl=0.
  - The ack then carries Err=1 and rdata=0, and the RAM is never written.
- ACCESS:
  - RAMAddr = {latched addr[AddrW-1:2], 2'b00}.
  - Fetch or load: capture RAMOut, ack next cycle, return to IDLE.
  - Word store: RAMDataIn = wdata, RAMWriteControl=1; ack next cycle, return to IDLE.
  - Byte or half store: capture RAMOut into the merge register, go to MERGE_WR.
- MERGE_WR:
  - Same RAMAddr as ACCESS; RAMWriteControl=1.
  - RAMDataIn = merge register with the selected lane replaced:
    - byte lane addr[1:0]: byte 0 is bits [7:0], little-endian;
    - half lane addr[1]: bits [15:0] or [31:16].
  - Ack next cycle, return to IDLE.
- Load extraction: select the lane as above, then sign- or zero-extend per LSUnsigned. Word loads pass unchanged.
- Latency, with req first high in cycle 0 and the FSM idle:
  - ack in cycle 2 for fetch, load, word store and error;
  - ack in cycle 3 for sub-word store.
  - A losing requester waits; back-to-back grants are possible in the ack cycle for the other port.
- Acks: IFAck and LSAck are registered single-cycle pulses, never both high in the same cycle. Err is 0 whenever ack is 0.
- Busy = (state != IDLE).

Test Plan:
- Reset and fetch:
  - nReset low -> all outputs 0.
  - Release, RAM word at 0x40 = 0x12345678; IFReq, IFAddr=0x40 in cycle 0 -> RAMAddr=0x40 in cycle 1; IFAck=1, IFData=0x12345678 in cycle 2; Busy=0 in cycle 2.
- Sub-word loads, RAM word at 0x100 = 0x80FF7F01:
  - LB 0x101 -> LSRData=0x0000007F;
  - LB 0x102 -> 0xFFFFFFFF;
  - LBU 0x102 -> 0x000000FF;
  - LH 0x102 -> 0xFFFF80FF;
  - LHU 0x102 -> 0x000080FF.
- Read-modify-write, RAM word at 0x200 = 0xAABBCCDD:
  - SB 0x201 wdata=0x11 -> RAMWriteControl high only in cycle 2; LSAck in cycle 3; RAM = 0xAABB11DD.
  - SH 0x202 wdata=0x5566 -> RAM = 0x556611DD.
- Errors:
  - SW 0x203 -> LSAck with LSErr=1 in cycle 2; RAMWriteControl never high; RAM unchanged.
  - LSSize=11 -> LSErr=1.
  - Fetch 0x42 -> IFErr=1.
- Arbitration:
  - IFReq and LSReq held high continuously, MaxDataBurst=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
  - Each ack is a single pulse; no duplicate acks.
- Abort: nReset low during MERGE_WR of SB 0x201 -> RAMWriteControl drops immediately; no LSAck; RAM word keeps its pre-store value after reset.
